// File: rtl/sd_bit_serializer_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sd_bit_serializer_pkg : state encodings and default idle level     |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
package sd_bit_serializer_pkg;

    typedef enum logic {
        SD_SER_IDLE  = 1'b0,
        SD_SER_SHIFT = 1'b1
    } ser_state_t;

    localparam logic SD_IDLE_BIT = 1'b0;

endpackage
`default_nettype wire

// File: rtl/sd_bit_serializer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sd_bit_serializer : parallel word to 1-bit-per-clock stream with   |
// | a one-word holding register for gapless back-to-back words.        |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
module sd_bit_serializer
    import sd_bit_serializer_pkg::*;
#(
    parameter int   WIDTH     = 8,
    parameter int   MSB_FIRST = 1,
    parameter logic IDLE_BIT  = SD_IDLE_BIT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             data_valid,
    output logic             data_ready,
    output logic             sout,
    output logic             bit_valid,
    output logic             word_done,
    output logic             busy
);

    localparam int               CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

    ser_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] hold;
    logic             hold_full;
    logic             accept;
    logic [CNT_W-1:0] cnt_next;

    // Bit driven for position idx of a word, honouring the shift order.
    function automatic logic order_bit(input logic [WIDTH-1:0] w,
                                       input logic [CNT_W-1:0] idx);
        if (MSB_FIRST != 0)
            return w[LAST - idx];
        else
            return w[idx];
    endfunction

    assign data_ready = !reset && !hold_full;
    assign accept     = data_valid && data_ready;
    assign busy       = (state == SD_SER_SHIFT) || hold_full;
    assign cnt_next   = cnt + CNT_W'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= SD_SER_IDLE;
            cnt       <= '0;
            shreg     <= '0;
            hold      <= '0;
            hold_full <= 1'b0;
            sout      <= IDLE_BIT;
            bit_valid <= 1'b0;
            word_done <= 1'b0;
        end else begin
            case (state)
                SD_SER_IDLE: begin
                    cnt       <= '0;
                    word_done <= 1'b0;
                    if (accept) begin
                        state     <= SD_SER_SHIFT;
                        shreg     <= data_in;
                        sout      <= order_bit(data_in, '0);
                        bit_valid <= 1'b1;
                    end else begin
                        sout      <= IDLE_BIT;
                        bit_valid <= 1'b0;
                    end
                end
                SD_SER_SHIFT: begin
                    if (cnt == LAST) begin
                        cnt       <= '0;
                        word_done <= 1'b0;
                        // Held word takes priority; data_ready is low then.
                        if (hold_full) begin
                            shreg     <= hold;
                            hold_full <= 1'b0;
                            sout      <= order_bit(hold, '0);
                            bit_valid <= 1'b1;
                        end else if (accept) begin
                            shreg     <= data_in;
                            sout      <= order_bit(data_in, '0);
                            bit_valid <= 1'b1;
                        end else begin
                            state     <= SD_SER_IDLE;
                            sout      <= IDLE_BIT;
                            bit_valid <= 1'b0;
                        end
                    end else begin
                        cnt       <= cnt_next;
                        sout      <= order_bit(shreg, cnt_next);
                        bit_valid <= 1'b1;
                        word_done <= (cnt_next == LAST);
                        if (accept) begin
                            hold      <= data_in;
                            hold_full <= 1'b1;
                        end
                    end
                end
                default: begin
                    state     <= SD_SER_IDLE;
                    sout      <= IDLE_BIT;
                    bit_valid <= 1'b0;
                    word_done <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sd_bit_serializer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_sd_bit_serializer : bench for MSB-first and LSB-first instances |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
module tb_sd_bit_serializer;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [W-1:0] data_in = '0;
    logic         data_valid = 1'b0;

    logic ready_m, sout_m, bv_m, wd_m, busy_m;
    logic ready_l, sout_l, bv_l, wd_l, busy_l;

    always #5 clk = ~clk;

    sd_bit_serializer #(.WIDTH(W), .MSB_FIRST(1), .IDLE_BIT(1'b0)) dut (
        .clk(clk), .reset(reset), .data_in(data_in), .data_valid(data_valid),
        .data_ready(ready_m), .sout(sout_m), .bit_valid(bv_m),
        .word_done(wd_m), .busy(busy_m));

    sd_bit_serializer #(.WIDTH(W), .MSB_FIRST(0), .IDLE_BIT(1'b0)) dut_lsb (
        .clk(clk), .reset(reset), .data_in(data_in), .data_valid(data_valid),
        .data_ready(ready_l), .sout(sout_l), .bit_valid(bv_l),
        .word_done(wd_l), .busy(busy_l));

    // Reference: a queue of line bits still to appear; a new word joins the tail.
    typedef struct packed {
        logic bm;
        logic bl;
        logic done;
    } ent_t;

    ent_t cur;
    logic cur_valid = 1'b0;
    ent_t q[$];

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic model_ready();
        return !reset && (q.size() < W);
    endfunction

    task automatic check_outputs(input string tag);
        logic exp_busy;
        exp_busy = cur_valid || (q.size() >= W);
        chk({tag, ".ready_m"}, ready_m, model_ready());
        chk({tag, ".ready_l"}, ready_l, model_ready());
        chk({tag, ".sout_m"},  sout_m,  cur_valid ? cur.bm : 1'b0);
        chk({tag, ".sout_l"},  sout_l,  cur_valid ? cur.bl : 1'b0);
        chk({tag, ".bv_m"},    bv_m,    cur_valid);
        chk({tag, ".bv_l"},    bv_l,    cur_valid);
        chk({tag, ".wd_m"},    wd_m,    cur_valid && cur.done);
        chk({tag, ".wd_l"},    wd_l,    cur_valid && cur.done);
        chk({tag, ".busy_m"},  busy_m,  exp_busy);
        chk({tag, ".busy_l"},  busy_l,  exp_busy);
    endtask

    // Drive at the falling edge, advance the model over the rising edge,
    // compare at the next falling edge.
    task automatic cycle(input string tag, input logic v, input logic [W-1:0] d,
                         output logic acc);
        ent_t e;
        data_valid = v;
        data_in    = d;
        acc = v && model_ready();
        @(posedge clk);
        if (acc) begin
            for (int i = 0; i < W; i++) begin
                e.bm   = d[W-1-i];
                e.bl   = d[i];
                e.done = (i == W - 1);
                q.push_back(e);
            end
        end
        if (q.size() > 0) begin
            cur       = q.pop_front();
            cur_valid = 1'b1;
        end else begin
            cur_valid = 1'b0;
        end
        @(negedge clk);
        check_outputs(tag);
    endtask

    task automatic model_reset();
        q.delete();
        cur_valid = 1'b0;
    endtask

    initial begin
        logic         acc;
        logic         v;
        logic [W-1:0] d;
        logic [W-1:0] cap_m;
        logic [W-1:0] cap_l;
        logic [W-1:0] words [2];
        int           n;

        // Reset held with a valid word offered: nothing accepted, line idle.
        reset      = 1'b1;
        data_valid = 1'b1;
        data_in    = 8'hFF;
        #1 check_outputs("rst0");
        @(negedge clk);
        check_outputs("rst1");
        #2 reset = 1'b0;
        data_valid = 1'b0;
        #1 chk("ready_after_rst_m", ready_m, 1'b1);
        chk("ready_after_rst_l", ready_l, 1'b1);
        @(negedge clk);
        check_outputs("post_rst");

        // Single word 0xB0, also captured as explicit bit sequences.
        cycle("single", 1'b1, 8'hB0, acc);
        chk("single_acc", acc, 1'b1);
        cap_m = '0;
        cap_l = '0;
        for (int i = 0; i < W; i++) begin
            if (i > 0) cycle("single", 1'b0, 8'h00, acc);
            cap_m = {cap_m[W-2:0], sout_m};
            cap_l = {cap_l[W-2:0], sout_l};
        end
        chk("single_seq_msb", cap_m, 8'b1011_0000);
        chk("single_seq_lsb", cap_l, 8'b0000_1101);
        for (int i = 0; i < 3; i++) cycle("single_tail", 1'b0, 8'h00, acc);

        // Continuous source, back to back.
        words[0] = 8'hB0;
        words[1] = 8'h0B;
        for (int w = 0; w < 2; w++) begin
            n   = 0;
            acc = 1'b0;
            while (!acc && n < 40) begin
                cycle("b2b", 1'b1, words[w], acc);
                n++;
            end
            chk("b2b_accept_in_time", acc, 1'b1);
        end
        for (int i = 0; i < 2 * W + 2; i++) cycle("b2b_drain", 1'b0, 8'h00, acc);

        // Bypass: valid arrives only on the last-bit cycle with hold empty.
        cycle("byp", 1'b1, 8'h5A, acc);
        n = 0;
        while (!(cur_valid && cur.done) && n < 20) begin
            cycle("byp_wait", 1'b0, 8'h00, acc);
            n++;
        end
        chk("byp_reached_last", cur_valid && cur.done, 1'b1);
        cycle("byp_go", 1'b1, 8'hC3, acc);
        chk("byp_acc", acc, 1'b1);
        chk("byp_no_hold_ready", ready_m, 1'b1);
        chk("byp_bit0", sout_m, 1'b1);
        for (int i = 0; i < W + 2; i++) cycle("byp_drain", 1'b0, 8'h00, acc);

        // Mid-word reset with a second word held.
        cycle("mrst", 1'b1, 8'hE7, acc);
        cycle("mrst", 1'b1, 8'h99, acc);
        chk("mrst_hold_acc", acc, 1'b1);
        cycle("mrst", 1'b0, 8'h00, acc);
        cycle("mrst", 1'b0, 8'h00, acc);
        #2 reset = 1'b1;
        model_reset();
        #1 check_outputs("mrst_async");
        @(negedge clk);
        check_outputs("mrst_held");
        reset = 1'b0;
        #1 check_outputs("mrst_release");
        @(negedge clk);
        for (int i = 0; i < 2 * W + 4; i++) cycle("mrst_quiet", 1'b0, 8'h00, acc);

        // Randomized source that holds each word until it is taken.
        v = 1'b0;
        d = '0;
        for (int i = 0; i < 600; i++) begin
            if (!v) begin
                v = ($urandom_range(0, 3) != 0);
                d = W'($urandom);
            end
            cycle("rand", v, d, acc);
            if (acc) v = 1'b0;
        end
        for (int i = 0; i < 2 * W + 2; i++) cycle("rand_drain", 1'b0, 8'h00, acc);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
